// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader
//
// Debug bus initiator for the p12 word memory. Commands arrive as a byte
// stream from a UART receiver, are parsed into single 32-bit read or write
// cycles on the memory bus, and the reply (ack byte or read data) leaves on
// a byte stream towards a UART transmitter. The memory bus is shared with
// the CPU, so every access first requests the bus from the arbiter.
//
// Command set (all multi-byte fields MSB first):
//   'W' 0x57 + 4 addr + 4 data -> write, reply 0x2E
//   'R' 0x52 + 4 addr          -> read, reply 4 data bytes
//   anything else in IDLE      -> reply 0x3F, no bus activity
//
// Optional feature, enabled by defining MEM_LOADER_AUTOINC_EN:
//   - address register increments after every completed access
//   - 'w' 0x77 + 4 data        -> write at the stored address
//   - 'r' 0x72                 -> read at the stored address
//   - 'A' 0x41 + 4 addr        -> set the address only, reply 0x2E
//   Without the macro these three bytes are unknown commands.
//
// Parameters:
//   ADDR_W   width of A; only the low ADDR_W bits of the shifted address stay
//   RD_LAT   cycles from the CS cycle to valid DI (1..3)
//
// Ports:
//   CLK       system clock, all logic on the rising edge
//   RESET_N   asynchronous active-low reset
//   RX_DATA   command byte in
//   RX_VALID  RX_DATA valid
//   RX_READY  loader accepts a byte (transfer = VALID & READY)
//   TX_DATA   response byte out
//   TX_VALID  TX_DATA valid
//   TX_READY  sink accepts the byte
//   BUS_REQ   memory bus request to the arbiter
//   BUS_GNT   memory bus grant from the arbiter
//   A         memory word address
//   DO        write data to memory
//   WR        write enable, qualified by CS
//   CS        memory chip select, single-cycle pulse
//   DI        read data from memory
//   BUSY      high whenever the loader is not idle
// ---------------------------------------------------------------------------
module mem_loader #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic [7:0]        TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY,
  output logic              BUS_REQ,
  input  logic              BUS_GNT,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       DO,
  output logic              WR,
  output logic              CS,
  input  logic [31:0]       DI,
  output logic              BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_REQ,
    S_ACC,
    S_RDW,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    CMD_WRITE,
    CMD_READ,
    CMD_SETADDR
  } cmd_t;

  localparam logic [7:0] BYTE_W   = 8'h57;
  localparam logic [7:0] BYTE_R   = 8'h52;
  localparam logic [7:0] REPLY_OK = 8'h2E;
  localparam logic [7:0] REPLY_UNK = 8'h3F;
`ifdef MEM_LOADER_AUTOINC_EN
  localparam logic [7:0] BYTE_SETA = 8'h41;
  localparam logic [7:0] BYTE_WINC = 8'h77;
  localparam logic [7:0] BYTE_RINC = 8'h72;
`endif

  // Last value of the read-latency counter; the capture happens in that cycle.
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t state;
  cmd_t   cmd;
  logic [1:0]  cnt;
  logic [1:0]  lat_cnt;
  logic [1:0]  bytes_left;
  logic [23:0] rd_rest;
  logic        rx_fire;
  logic [ADDR_W-1:0] addr_shift;
`ifdef MEM_LOADER_AUTOINC_EN
  logic        did_access;
`endif

  // A byte is consumed only when both sides agree; RX_READY is a register,
  // so the sender sees a stable ready for the whole cycle.
  assign rx_fire = RX_VALID & RX_READY;

  // Address bytes shift in from the right; bytes pushed beyond ADDR_W fall off
  // the top, so narrow address buses just keep the low-order bytes.
  assign addr_shift = ADDR_W'({A, RX_DATA});

  // Whole loader: command parser, bus sequencer and reply serialiser in one
  // state machine. All outputs are registers updated together with the state
  // so that they reflect the state being entered. A and DO double as the
  // address and data shift registers, which keeps them stable from REQ until
  // the loader returns to IDLE. Read data goes to a separate shift register
  // (TX_DATA plus rd_rest) so DO is never disturbed by a read.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      cmd        <= CMD_READ;
      cnt        <= 2'd0;
      lat_cnt    <= 2'd0;
      bytes_left <= 2'd0;
      rd_rest    <= 24'd0;
`ifdef MEM_LOADER_AUTOINC_EN
      did_access <= 1'b0;
`endif
      A          <= '0;
      DO         <= 32'd0;
      RX_READY   <= 1'b0;
      TX_DATA    <= 8'd0;
      TX_VALID   <= 1'b0;
      BUS_REQ    <= 1'b0;
      WR         <= 1'b0;
      CS         <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Coming out of reset RX_READY is low; it rises on the first clock.
          RX_READY <= 1'b1;
          if (rx_fire) begin
            BUSY <= 1'b1;
            cnt  <= 2'd0;
            case (RX_DATA)
              BYTE_W: begin
                cmd   <= CMD_WRITE;
                state <= S_ADDR;
              end
              BYTE_R: begin
                cmd   <= CMD_READ;
                state <= S_ADDR;
              end
`ifdef MEM_LOADER_AUTOINC_EN
              BYTE_SETA: begin
                cmd   <= CMD_SETADDR;
                state <= S_ADDR;
              end
              BYTE_WINC: begin
                cmd   <= CMD_WRITE;
                state <= S_DATA;
              end
              BYTE_RINC: begin
                cmd      <= CMD_READ;
                state    <= S_REQ;
                RX_READY <= 1'b0;
                BUS_REQ  <= 1'b1;
              end
`endif
              default: begin
                state      <= S_RESP;
                RX_READY   <= 1'b0;
                TX_VALID   <= 1'b1;
                TX_DATA    <= REPLY_UNK;
                bytes_left <= 2'd0;
              end
            endcase
          end
        end

        S_ADDR: begin
          if (rx_fire) begin
            A   <= addr_shift;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              case (cmd)
                CMD_WRITE: state <= S_DATA;
                CMD_READ: begin
                  state    <= S_REQ;
                  RX_READY <= 1'b0;
                  BUS_REQ  <= 1'b1;
                end
                default: begin
                  // Address-only command: acknowledge without touching the bus.
                  state      <= S_RESP;
                  RX_READY   <= 1'b0;
                  TX_VALID   <= 1'b1;
                  TX_DATA    <= REPLY_OK;
                  bytes_left <= 2'd0;
                end
              endcase
            end
          end
        end

        S_DATA: begin
          if (rx_fire) begin
            DO  <= {DO[23:0], RX_DATA};
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state    <= S_REQ;
              RX_READY <= 1'b0;
              BUS_REQ  <= 1'b1;
            end
          end
        end

        S_REQ: begin
          // No timeout: the loader waits as long as the CPU holds the bus.
          if (BUS_GNT) begin
            state <= S_ACC;
            CS    <= 1'b1;
            WR    <= (cmd == CMD_WRITE);
          end
        end

        S_ACC: begin
          // The access is committed once CS has been issued, whatever the
          // grant does afterwards.
          CS <= 1'b0;
          WR <= 1'b0;
`ifdef MEM_LOADER_AUTOINC_EN
          did_access <= 1'b1;
`endif
          if (cmd == CMD_WRITE) begin
            state      <= S_RESP;
            BUS_REQ    <= 1'b0;
            TX_VALID   <= 1'b1;
            TX_DATA    <= REPLY_OK;
            bytes_left <= 2'd0;
          end else begin
            state   <= S_RDW;
            lat_cnt <= 2'd0;
          end
        end

        S_RDW: begin
          if (lat_cnt == LAT_LAST) begin
            state      <= S_RESP;
            BUS_REQ    <= 1'b0;
            TX_VALID   <= 1'b1;
            TX_DATA    <= DI[31:24];
            rd_rest    <= DI[23:0];
            bytes_left <= 2'd3;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        S_RESP: begin
          // TX_VALID is always high here; each accepted byte is replaced by the
          // next one on the following cycle, so a ready sink gets 1 byte/cycle.
          if (TX_READY) begin
            if (bytes_left == 2'd0) begin
              state    <= S_IDLE;
              TX_VALID <= 1'b0;
              BUSY     <= 1'b0;
              RX_READY <= 1'b1;
`ifdef MEM_LOADER_AUTOINC_EN
              // Advance only after a real bus cycle, not after 'A' or '?'.
              if (did_access) begin
                A <= A + ADDR_W'(1);
              end
              did_access <= 1'b0;
`endif
            end else begin
              TX_DATA    <= rd_rest[23:16];
              rd_rest    <= {rd_rest[15:0], 8'h00};
              bytes_left <= bytes_left - 2'd1;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
